// File: rtl/barrett_719_sched.sv
// Two-requester Barrett reducer for Q = 719.
// A round-robin arbiter picks one 19-bit operand. A multi-cycle FSM then
// computes x mod Q using one shared multiplier and returns the 10-bit
// remainder with the owner's id on a valid/ready handshake.
module barrett_719_sched #(
    parameter int unsigned Q  = 719,
    parameter int unsigned MU = 1458,
    parameter int unsigned K  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [18:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [18:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [9:0]  out_data,
    output logic        out_id,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL1 = 3'd1;
    localparam logic [2:0] S_MUL2 = 3'd2;
    localparam logic [2:0] S_CORR = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [20:0] Q_R  = 21'(Q);
    localparam logic [10:0] Q_M  = 11'(Q);
    localparam logic [10:0] MU_M = 11'(MU);

    logic [2:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [18:0] x_q, x_d;
    logic [20:0] prod_q, prod_d;
    logic [9:0]  out_data_q, out_data_d;
    logic        out_id_q, out_id_d;

    logic        idle;
    logic        grant0, grant1;
    logic [9:0]  mul_a;
    logic [10:0] mul_b;
    logic [20:0] mul_p;

    // The quotient estimate undershoots by at most two, so at most two
    // conditional subtractions bring the remainder into [0, Q).
    function automatic logic [9:0] barrett_correct(input logic [20:0] r_in);
        logic [20:0] r;
        r = r_in;
        if (r >= Q_R) r = r - Q_R;
        if (r >= Q_R) r = r - Q_R;
        return 10'(r);
    endfunction

    // Round-robin arbitration: the requester not granted last wins a tie.
    always_comb begin
        idle       = (state_q == S_IDLE);
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = idle && !rst && grant0;
        req1_ready = idle && !rst && grant1;
    end

    // Operand mux for the single multiplier shared by MUL1 and MUL2.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_MUL1: begin
                mul_a = 10'(x_q >> K);
                mul_b = MU_M;
            end
            S_MUL2: begin
                mul_a = 10'(prod_q >> K);
                mul_b = Q_M;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        mul_p = 21'(mul_a) * 21'(mul_b);
    end

    // Next-state and datapath update for the reduction sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        prod_d       = prod_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    x_d          = req0_data;
                    out_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_MUL1;
                end else if (req1_ready) begin
                    x_d          = req1_data;
                    out_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_MUL1;
                end
            end
            S_MUL1: begin
                prod_d  = mul_p;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                prod_d  = mul_p;
                state_d = S_CORR;
            end
            S_CORR: begin
                out_data_d = barrett_correct({2'b00, x_q} - prod_q);
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            out_data_q   <= '0;
            out_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
        end
    end

    // Operand and product registers; only meaningful while busy.
    always_ff @(posedge clk) begin
        x_q    <= x_d;
        prod_q <= prod_d;
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
